// File: rtl/display_scheduler_if.sv
// Bundle between the content sources, the display scheduler and the DispHexMux.
// The scheduler connects through the slave modport. The driving side uses the master modport.
interface display_scheduler_if;
  logic        tick;
  logic        hold;
  logic [3:0]  req;
  logic [59:0] src_hex;
  logic [11:0] src_dp;
  logic [4:0]  hex2;
  logic [4:0]  hex1;
  logic [4:0]  hex0;
  logic [2:0]  dp;
  logic [2:0]  en_mask;
  logic [3:0]  grant;
  logic [1:0]  sel;

  modport master (
    output tick, hold, req, src_hex, src_dp,
    input  hex2, hex1, hex0, dp, en_mask, grant, sel
  );

  modport slave (
    input  tick, hold, req, src_hex, src_dp,
    output hex2, hex1, hex0, dp, en_mask, grant, sel
  );
endinterface

// File: rtl/display_scheduler.sv
// Round-robin time-sharing of the 3-digit display between four content sources.
// A blank tick separates slots that belong to different sources.
module display_scheduler #(
  parameter int DWELL_TICKS = 4
) (
  input logic clk,
  input logic reset,
  display_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL_TICKS - 1);

  state_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [7:0]  dwell_q, dwell_d;
  logic [1:0]  nxt_q, nxt_d;
  logic [3:0]  grant_q, grant_d;
  logic [2:0]  en_q, en_d;
  logic [14:0] hex_q, hex_d;
  logic [2:0]  dp_q, dp_d;
  logic [2:0]  pick;
  logic        slot_end;

  // The result is {found, index}. It holds the first requester at or after start, wrapping modulo 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] k;
    res = 3'b000;
    for (int i = 0; i < 4; i++) begin
      k = start + i[1:0];
      if (!res[2] && r[k]) res = {1'b1, k};
    end
    return res;
  endfunction

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    dwell_d  = dwell_q;
    nxt_d    = nxt_q;
    pick     = 3'b000;
    slot_end = 1'b0;
    unique case (state_q)
      IDLE: begin
        pick = rr_pick(bus.req, ptr_q);
        if (pick[2]) begin
          state_d = SHOW;
          sel_d   = pick[1:0];
          dwell_d = 8'd0;
        end
      end
      SHOW: begin
        slot_end = !bus.req[sel_q] ||
                   (bus.tick && !bus.hold && dwell_q == DWELL_LAST);
        if (slot_end) begin
          ptr_d = sel_q + 2'd1;
          pick  = rr_pick(bus.req, sel_q + 2'd1);
          if (!pick[2]) begin
            state_d = IDLE;
          end else if (pick[1:0] == sel_q) begin
            dwell_d = 8'd0;
          end else begin
            state_d = GAP;
            nxt_d   = pick[1:0];
          end
        end else if (bus.tick && !bus.hold) begin
          dwell_d = dwell_q + 8'd1;
        end
      end
      GAP: begin
        if (bus.tick) begin
          // Requests that appeared during the gap are seen only by this re-pick.
          pick = bus.req[nxt_q] ? {1'b1, nxt_q} : rr_pick(bus.req, ptr_q);
          if (pick[2]) begin
            state_d = SHOW;
            sel_d   = pick[1:0];
            dwell_d = 8'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are loaded from the next-state values so that they line up with the state.
  always_comb begin
    grant_d = 4'b0000;
    en_d    = 3'b000;
    hex_d   = 15'd0;
    dp_d    = 3'b000;
    if (state_d == SHOW) begin
      grant_d = 4'b0001 << sel_d;
      en_d    = 3'b111;
      hex_d   = bus.src_hex[15*sel_d +: 15];
      dp_d    = bus.src_dp[3*sel_d +: 3];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      dwell_q <= 8'd0;
      nxt_q   <= 2'd0;
      grant_q <= 4'b0000;
      en_q    <= 3'b000;
      hex_q   <= 15'd0;
      dp_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      dwell_q <= dwell_d;
      nxt_q   <= nxt_d;
      grant_q <= grant_d;
      en_q    <= en_d;
      hex_q   <= hex_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.en_mask = en_q;
  assign bus.hex2    = hex_q[14:10];
  assign bus.hex1    = hex_q[9:5];
  assign bus.hex0    = hex_q[4:0];
  assign bus.dp      = dp_q;
  assign bus.sel     = sel_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler with two instances, one with a dwell of 4 and one with a dwell of 1.
// Both instances are compared every cycle against an abstract slot/gap reference model.
module tb_display_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        tick;
  logic        hold;
  logic [3:0]  req;
  logic [59:0] src_hex;
  logic [11:0] src_dp;

  int checks = 0;
  int errors = 0;

  display_scheduler_if ifa();
  display_scheduler_if ifb();

  assign ifa.tick = tick;  assign ifa.hold = hold;  assign ifa.req = req;
  assign ifa.src_hex = src_hex;  assign ifa.src_dp = src_dp;
  assign ifb.tick = tick;  assign ifb.hold = hold;  assign ifb.req = req;
  assign ifb.src_hex = src_hex;  assign ifb.src_dp = src_dp;

  display_scheduler #(.DWELL_TICKS(4)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  display_scheduler #(.DWELL_TICKS(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  // Reference model: the owner is the source on screen (-1 when the display is blank).
  // left is the number of ticks remaining in the current slot.
  int          m_owner[2];
  int          m_left[2];
  int          m_ptr[2];
  int          m_next[2];
  int          m_last[2];
  bit          m_gap[2];
  int          m_dw[2] = '{4, 1};
  logic [26:0] exp_out[2];

  function automatic int first_req(input int start);
    for (int i = 0; i < 4; i++)
      if (req[(start + i) % 4]) return (start + i) % 4;
    return -1;
  endfunction

  task automatic model_step(input int j);
    int k;
    if (reset) begin
      m_owner[j] = -1; m_left[j] = 0; m_ptr[j] = 0;
      m_next[j] = 0; m_last[j] = 0; m_gap[j] = 1'b0;
    end else if (m_owner[j] >= 0) begin
      if (!req[m_owner[j]] || (tick && !hold && m_left[j] == 1)) begin
        m_ptr[j] = (m_owner[j] + 1) % 4;
        k = first_req(m_ptr[j]);
        if (k < 0) m_owner[j] = -1;
        else if (k == m_owner[j]) m_left[j] = m_dw[j];
        else begin
          m_owner[j] = -1; m_gap[j] = 1'b1; m_next[j] = k;
        end
      end else if (tick && !hold) begin
        m_left[j] = m_left[j] - 1;
      end
    end else if (m_gap[j]) begin
      if (tick) begin
        m_gap[j] = 1'b0;
        k = req[m_next[j]] ? m_next[j] : first_req(m_ptr[j]);
        if (k >= 0) begin
          m_owner[j] = k; m_last[j] = k; m_left[j] = m_dw[j];
        end
      end
    end else begin
      k = first_req(m_ptr[j]);
      if (k >= 0) begin
        m_owner[j] = k; m_last[j] = k; m_left[j] = m_dw[j];
      end
    end
    if (reset) exp_out[j] = 27'd0;
    else if (m_owner[j] >= 0)
      exp_out[j] = {4'(1 << m_owner[j]), 2'(m_last[j]), 3'b111,
                    src_hex[15*m_owner[j] +: 15], src_dp[3*m_owner[j] +: 3]};
    else
      exp_out[j] = {4'b0000, 2'(m_last[j]), 21'd0};
  endtask

  function automatic logic [26:0] dut_out(input int j);
    if (j == 0)
      return {ifa.grant, ifa.sel, ifa.en_mask, ifa.hex2, ifa.hex1, ifa.hex0, ifa.dp};
    return {ifb.grant, ifb.sel, ifb.en_mask, ifb.hex2, ifb.hex1, ifb.hex0, ifb.dp};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check("model_dwell4", 32'(dut_out(0)), 32'(exp_out[0]));
    check("model_dwell1", 32'(dut_out(1)), 32'(exp_out[1]));
  endtask

  task automatic do_reset();
    reset = 1'b1; tick = 1'b0; hold = 1'b0; req = 4'b0000;
    cycle();
    reset = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; cycle();
      tick = 1'b0; cycle();
    end
  endtask

  typedef struct {
    logic       rst;
    logic       tk;
    logic       hd;
    logic [3:0] rq;
    logic [3:0] g;
    logic [2:0] en;
  } vec_t;

  vec_t tbl[19];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 4'b0101, 4'b0000, 3'b000};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 4'b0101, 4'b0000, 3'b000};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 4'b0101, 4'b0001, 3'b111};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 4'b0101, 4'b0001, 3'b111};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 4'b0101, 4'b0001, 3'b111};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 4'b0101, 4'b0001, 3'b111};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 4'b0101, 4'b0000, 3'b000};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 4'b0101, 4'b0100, 3'b111};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 4'b0101, 4'b0100, 3'b111};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 4'b0101, 4'b0100, 3'b111};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 4'b0101, 4'b0100, 3'b111};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 4'b0101, 4'b0000, 3'b000};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 4'b0101, 4'b0000, 3'b000};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 4'b0101, 4'b0001, 3'b111};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'b000};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 4'b0010, 4'b0010, 3'b111};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 4'b0010, 4'b0010, 3'b111};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 4'b0010, 4'b0000, 3'b000};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 4'b1000, 4'b1000, 3'b111};

    reset = 1'b1; tick = 1'b0; hold = 1'b0; req = 4'b0000;
    src_hex = {28'($urandom), $urandom};
    src_dp  = 12'($urandom);

    for (int i = 0; i < 19; i++) begin
      reset = tbl[i].rst; tick = tbl[i].tk; hold = tbl[i].hd; req = tbl[i].rq;
      cycle();
      check("tbl_grant", 32'(ifa.grant), 32'(tbl[i].g));
      check("tbl_en", 32'(ifa.en_mask), 32'(tbl[i].en));
    end

    // Reset with every source requesting and tick pulsing.
    req = 4'b1111; reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick = i[0];
      cycle();
      check("reset_outputs", 32'(dut_out(0)), 32'd0);
    end
    reset = 1'b0; tick = 1'b0;
    cycle();
    check("reset_release_grant", 32'(ifa.grant), 32'h1);

    // A single source keeps the display with no gap, and live data follows with a delay of 1 cycle.
    do_reset();
    req = 4'b0001;
    cycle();
    for (int i = 0; i < 12; i++) begin
      tick = 1'b1; cycle();
      check("single_grant", 32'(ifa.grant), 32'h1);
      check("single_en", 32'(ifa.en_mask), 32'h7);
      tick = 1'b0; cycle();
    end
    src_hex[14:0] = 15'h1234;
    cycle();
    check("single_hex", 32'({ifa.hex2, ifa.hex1, ifa.hex0}), 32'h1234);

    // Early release on a tick cycle.
    do_reset();
    req = 4'b0011;
    cycle();
    ticks(2);
    tick = 1'b1; req = 4'b0010;
    cycle();
    check("early_gap", 32'(ifa.grant), 32'h0);
    tick = 1'b0;
    cycle();
    check("early_gap_wait", 32'(ifa.en_mask), 32'h0);
    tick = 1'b1;
    cycle();
    check("early_next", 32'(ifa.grant), 32'h2);
    tick = 1'b0;

    // Hold freezes the dwell count.
    do_reset();
    req = 4'b0110;
    cycle();
    check("hold_start", 32'(ifa.grant), 32'h2);
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ticks(1);
      check("hold_frozen", 32'(ifa.grant), 32'h2);
    end
    hold = 1'b0;
    ticks(3);
    check("hold_resume", 32'(ifa.grant), 32'h2);
    tick = 1'b1;
    cycle();
    check("hold_end", 32'(ifa.grant), 32'h0);
    tick = 1'b0;

    // The next requester drops out during the gap.
    do_reset();
    req = 4'b0011;
    cycle();
    ticks(4);
    check("vanish_gap", 32'(ifa.grant), 32'h0);
    req = 4'b0001;
    cycle();
    tick = 1'b1;
    cycle();
    check("vanish_repick", 32'(ifa.grant), 32'h1);
    tick = 1'b0;
    do_reset();
    req = 4'b0011;
    cycle();
    ticks(4);
    req = 4'b0000; tick = 1'b1;
    cycle();
    check("vanish_idle", 32'({ifa.grant, ifa.en_mask, ifa.hex2, ifa.hex1, ifa.hex0, ifa.dp}), 32'd0);
    tick = 1'b0;

    // Randomized traffic that includes bursts with tick high every cycle.
    begin
      int burst;
      burst = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 99) == 0) burst = $urandom_range(5, 40);
        tick  = (burst > 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
        if (burst > 0) burst--;
        hold  = ($urandom_range(0, 7) == 0);
        reset = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 9) == 0) req = 4'($urandom);
        if ($urandom_range(0, 3) == 0) src_hex = {28'($urandom), $urandom};
        if ($urandom_range(0, 3) == 0) src_dp = 12'($urandom);
        cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Time-shares the 3-digit seven-segment display between up to four content sources. Each requesting source gets a round-robin slot of DWELL_TICKS strobes. Switches between different sources are separated by one blank tick. The block sits between the content generators (heartbeat, counters, status) and the DispHexMux hex multiplexer, and is paced by the FrequencyDivider tick.

## Interface
- DWELL_TICKS, 4, ticks per slot; legal range 1..255; dwell counter is 8 bits.
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  one-cycle pacing strobe from FrequencyDivider.
- hold  input  1  while high, the dwell counter does not advance (rotation paused).
- req  input  4  level request per source; bit i = source i.
- src_hex  input  60  source i digits at [15i+14:15i], order hex2,hex1,hex0 (MSB first), 5 bits each, passed through unchanged.
- src_dp  input  12  source i decimal points at [3i+2:3i].
- hex2, hex1, hex0  output  5 each  digits to DispHexMux.
- dp  output  3  decimal points to DispHexMux.
- en_mask  output  3  digit enables to DispHexMux; 3'b111 = all on, 3'b000 = blank.
- grant  output  4  one-hot granted source; 0 when none.
- sel  output  2  index of the granted source.

## Operation
- States: IDLE, SHOW, GAP. Registers: state, sel, ptr (2 bits), dwell (8 bits), nxt (2 bits).
- Round-robin pick from ptr: the first index k in ptr, ptr+1, … (mod 4) with req[k]=1.
- IDLE:
  - Leave when any req bit is set.
  - Go to SHOW with sel = pick from ptr and dwell = 0.
- SHOW, end of slot, triggered by either:
  - req[sel]=0; this wins over any tick in the same cycle; or
  - a tick with hold=0 and dwell = DWELL_TICKS-1.
- SHOW, otherwise: a tick with hold=0 increments dwell.
- On end of slot, ptr ← sel+1 and the next source is picked from sel+1:
  - No requester → IDLE.
  - Pick equals sel (only requester) → stay in SHOW, dwell ← 0, no gap.
  - Otherwise → GAP with nxt ← pick.
- GAP:
  - Waits for the next tick; hold does not affect GAP.
  - On that tick, if req[nxt]=1 → SHOW, sel ← nxt, dwell ← 0.
  - Else re-pick from ptr: none → IDLE, otherwise → SHOW with that pick.
- All outputs are registered and loaded from next-state values, so they align with state:
  - SHOW: grant = one-hot(sel), en_mask = 111. hex2/1/0 and dp load from the source of next sel every cycle, so live source data appears 1 cycle after it changes.
  - IDLE/GAP: grant = 0, en_mask = 000, hex2/1/0 = 0, dp = 0. sel holds its last value.
- Reset value of every register and output is 0; the state after reset is IDLE.

## Timing
- Arbitration latency: req rising in cycle N (from IDLE) gives state=SHOW, grant and data valid in cycle N+1.
- Slot length: exactly DWELL_TICKS ticks, counted from the first tick after SHOW entry. The slot ends in the cycle after the final tick.
- Gap: from GAP entry until the next tick, plus 1 cycle.
- Early release: req[sel] falling in cycle N gives the GAP/IDLE/SHOW transition in cycle N+1, regardless of dwell count or tick.
- DWELL_TICKS=1: every tick ends the slot.
- tick high every cycle: the block must still follow the same per-tick rules (no skipped slots).
- Reset takes priority over every other input, including mid-SHOW and mid-GAP.
- Requests arriving during GAP are considered only at the GAP-exit re-pick.

## Test plan
- Reset: hold reset 3 cycles with req=1111 and tick pulsing → all outputs 0 during reset. After release: grant=0001 one cycle later.
- Single source: req=0001, DWELL_TICKS=4, 12 ticks → grant stays 0001, en_mask=111 every cycle, no GAP. Changing src_hex[14:0] shows on hex outputs 1 cycle later.
- Rotation: req=0101 → source 0 for 4 ticks, blank (grant 0000, en_mask 000) until the next tick, source 2 for 4 ticks, blank, then source 0.
- Early release: req=0011 and sel=0; drop req[0] after 2 ticks in the same cycle as a tick → next cycle GAP with nxt=1; source 1 is shown after the next tick.
- Hold: during a source-1 slot with req=0110, hold=1 across 10 ticks → grant stays 0010, dwell frozen. After hold drops, 4 more ticks are needed before the slot ends (dwell was 0 when hold rose).
- Requester vanishes in GAP: req=0011, in GAP with nxt=1; clear req[1] before the tick → SHOW source 0 after the tick. With req=0000 instead → IDLE, all outputs 0.
